// File: rtl/neuron_pkg.sv
// Shared types and constants for the neuron dispatcher slice.
package neuron_pkg;

  localparam int unsigned WT_W   = 17;
  localparam int unsigned ACT_W  = 27;
  localparam int unsigned FAN_IN = 9;
  localparam int unsigned IDX_W  = 4;

  localparam logic [FAN_IN-1:0] START_ALL = 9'h1ff;

  typedef enum logic [1:0] {
    StCollect,
    StIssue,
    StWait,
    StEmit
  } disp_state_e;

endpackage

// File: rtl/neuron_dispatcher_if.sv
// Bus bundle between the dispatcher, its upstream/downstream and the neuron engine.
// master: dispatcher side; slave: environment (weight loader, source, neuron, sink).
interface neuron_dispatcher_if;
  import neuron_pkg::*;

  logic                    wt_wr_en;
  logic [IDX_W-1:0]        wt_wr_nrn;
  logic [IDX_W-1:0]        wt_wr_tap;
  logic [WT_W-1:0]         wt_wr_data;
  logic                    wt_wr_ack;

  logic                    act_valid;
  logic                    act_ready;
  logic [ACT_W-1:0]        act_data;

  logic [FAN_IN*WT_W-1:0]  n_weights;
  logic [FAN_IN*ACT_W-1:0] n_inputs;
  logic [FAN_IN-1:0]       n_start;
  logic [ACT_W-1:0]        n_out;
  logic                    n_end;

  logic                    res_valid;
  logic                    res_ready;
  logic [ACT_W-1:0]        res_data;
  logic [IDX_W-1:0]        res_idx;
  logic                    res_err;
  logic                    busy;

  modport master (
    input  wt_wr_en, wt_wr_nrn, wt_wr_tap, wt_wr_data,
    output wt_wr_ack,
    input  act_valid, act_data,
    output act_ready,
    output n_weights, n_inputs, n_start,
    input  n_out, n_end,
    output res_valid, res_data, res_idx, res_err, busy,
    input  res_ready
  );

  modport slave (
    output wt_wr_en, wt_wr_nrn, wt_wr_tap, wt_wr_data,
    input  wt_wr_ack,
    output act_valid, act_data,
    input  act_ready,
    input  n_weights, n_inputs, n_start,
    output n_out, n_end,
    input  res_valid, res_data, res_idx, res_err, busy,
    output res_ready
  );

endinterface

// File: rtl/neuron_weight_bank.sv
// NUM_NEURONS x FAN_IN weight register file: one write port, one full-row read port.
// Storage is deliberately not reset; weights survive a dispatcher reset.
module neuron_weight_bank
  import neuron_pkg::*;
#(
  parameter int unsigned NUM_NEURONS = 4
) (
  input  logic                   clk_i,
  input  logic                   wr_en_i,
  input  logic [IDX_W-1:0]       wr_nrn_i,
  input  logic [IDX_W-1:0]       wr_tap_i,
  input  logic [WT_W-1:0]        wr_data_i,
  input  logic [IDX_W-1:0]       rd_nrn_i,
  output logic [FAN_IN*WT_W-1:0] rd_row_o
);

  logic [WT_W-1:0] mem_q [NUM_NEURONS][FAN_IN];

  // Write one tap; indices are decoded by compare so out-of-range never aliases.
  always_ff @(posedge clk_i) begin
    for (int unsigned r = 0; r < NUM_NEURONS; r++) begin
      for (int unsigned t = 0; t < FAN_IN; t++) begin
        if (wr_en_i && wr_nrn_i == IDX_W'(r) && wr_tap_i == IDX_W'(t)) begin
          mem_q[r][t] <= wr_data_i;
        end
      end
    end
  end

  // Present the selected row packed tap 0 in the LSBs.
  always_comb begin
    rd_row_o = '0;
    for (int unsigned r = 0; r < NUM_NEURONS; r++) begin
      if (rd_nrn_i == IDX_W'(r)) begin
        for (int unsigned t = 0; t < FAN_IN; t++) begin
          rd_row_o[t*WT_W +: WT_W] = mem_q[r][t];
        end
      end
    end
  end

endmodule

// File: rtl/neuron_dispatcher.sv
// Layer-level initiator time-multiplexing one neuron MAC engine over NUM_NEURONS
// weight sets. Optional WAIT watchdog enabled by defining DISPATCH_TIMEOUT_EN.
module neuron_dispatcher
  import neuron_pkg::*;
#(
  parameter int unsigned NUM_NEURONS = 4,
  parameter int unsigned TIMEOUT     = 64
) (
  input logic                clk,
  input logic                rst,
  neuron_dispatcher_if.master bus
);

  disp_state_e             state_q;
  logic [IDX_W-1:0]        act_cnt_q;
  logic [IDX_W-1:0]        nrn_idx_q;
  logic [IDX_W-1:0]        res_idx_q;
  logic [ACT_W-1:0]        res_data_q;
  logic                    n_end_q;
  logic                    wt_wr_ack_q;
  logic [ACT_W-1:0]        taps_q [FAN_IN];
  logic [FAN_IN*WT_W-1:0]  wt_row;
  logic [FAN_IN*ACT_W-1:0] taps_flat;
  logic                    collecting;
  logic                    act_fire;
  logic                    wt_commit;
  logic                    end_rise;
  logic                    last_nrn;

  assign collecting = (state_q == StCollect);
  assign act_fire   = collecting && bus.act_valid;
  assign wt_commit  = collecting && bus.wt_wr_en &&
                      (32'(bus.wt_wr_nrn) < NUM_NEURONS) &&
                      (32'(bus.wt_wr_tap) < FAN_IN);
  // A level already high on WAIT entry is not a completion.
  assign end_rise   = bus.n_end && !n_end_q;
  assign last_nrn   = (nrn_idx_q == IDX_W'(NUM_NEURONS - 1));

  neuron_weight_bank #(
    .NUM_NEURONS(NUM_NEURONS)
  ) u_bank (
    .clk_i    (clk),
    .wr_en_i  (wt_commit),
    .wr_nrn_i (bus.wt_wr_nrn),
    .wr_tap_i (bus.wt_wr_tap),
    .wr_data_i(bus.wt_wr_data),
    .rd_nrn_i (nrn_idx_q),
    .rd_row_o (wt_row)
  );

`ifdef DISPATCH_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
  logic [TmoW-1:0] tmo_q;
  logic            res_err_q;
  assign bus.res_err = res_err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign bus.res_err    = 1'b0;
`endif

  // Activation tap capture; not reset, only consumed after a full vector.
  always_ff @(posedge clk) begin
    for (int unsigned t = 0; t < FAN_IN; t++) begin
      if (act_fire && act_cnt_q == IDX_W'(t)) begin
        taps_q[t] <= bus.act_data;
      end
    end
  end

  // Dispatcher FSM with result capture and write acknowledge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StCollect;
      act_cnt_q   <= '0;
      nrn_idx_q   <= '0;
      res_idx_q   <= '0;
      res_data_q  <= '0;
      n_end_q     <= 1'b0;
      wt_wr_ack_q <= 1'b0;
`ifdef DISPATCH_TIMEOUT_EN
      tmo_q       <= '0;
      res_err_q   <= 1'b0;
`endif
    end else begin
      n_end_q     <= bus.n_end;
      wt_wr_ack_q <= wt_commit;
      unique case (state_q)
        StCollect: begin
          if (act_fire) begin
            if (act_cnt_q == IDX_W'(FAN_IN - 1)) begin
              act_cnt_q <= '0;
              nrn_idx_q <= '0;
              state_q   <= StIssue;
            end else begin
              act_cnt_q <= act_cnt_q + 1'b1;
            end
          end
        end
        StIssue: begin
`ifdef DISPATCH_TIMEOUT_EN
          tmo_q   <= '0;
`endif
          state_q <= StWait;
        end
        StWait: begin
          if (end_rise) begin
            res_data_q <= bus.n_out;
            res_idx_q  <= nrn_idx_q;
`ifdef DISPATCH_TIMEOUT_EN
            res_err_q  <= 1'b0;
`endif
            state_q    <= StEmit;
          end
`ifdef DISPATCH_TIMEOUT_EN
          else if (tmo_q == TmoW'(TIMEOUT - 1)) begin
            res_data_q <= '0;
            res_idx_q  <= nrn_idx_q;
            res_err_q  <= 1'b1;
            state_q    <= StEmit;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
`endif
        end
        StEmit: begin
          if (bus.res_ready) begin
`ifdef DISPATCH_TIMEOUT_EN
            res_err_q <= 1'b0;
`endif
            if (last_nrn) begin
              act_cnt_q <= '0;
              state_q   <= StCollect;
            end else begin
              nrn_idx_q <= nrn_idx_q + 1'b1;
              state_q   <= StIssue;
            end
          end
        end
        default: state_q <= StCollect;
      endcase
    end
  end

  // Pack activation taps, tap 0 in the LSBs.
  always_comb begin
    taps_flat = '0;
    for (int unsigned t = 0; t < FAN_IN; t++) begin
      taps_flat[t*ACT_W +: ACT_W] = taps_q[t];
    end
  end

  // Outputs decode from registered state; operands are quiet while collecting.
  assign bus.act_ready = collecting;
  assign bus.busy      = !collecting;
  assign bus.n_start   = (state_q == StIssue) ? START_ALL : '0;
  assign bus.n_weights = collecting ? '0 : wt_row;
  assign bus.n_inputs  = collecting ? '0 : taps_flat;
  assign bus.res_valid = (state_q == StEmit);
  assign bus.res_data  = res_data_q;
  assign bus.res_idx   = res_idx_q;
  assign bus.wt_wr_ack = wt_wr_ack_q;

endmodule
